// File: rtl/if_stage_pkg.sv
// Shared constants and the per-edge action decode for the fetch stage.
package if_stage_pkg;
    localparam int          XLEN_D      = 32;
    localparam int          ADDR_W_D    = 6;
    localparam int          CNT_W_D     = 16;
    localparam logic [31:0] RESET_PC_D  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_D = 32'h0000_0013;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_MEM_BUSY,
        ACT_STALL,
        ACT_FLUSH
    } if_act_e;

    // Redirects win over everything; a stall also masks a memory-port conflict.
    function automatic if_act_e if_action(input logic flush, input logic stall,
                                          input logic mem_busy);
        if (flush)         return ACT_FLUSH;
        else if (stall)    return ACT_STALL;
        else if (mem_busy) return ACT_MEM_BUSY;
        else               return ACT_NORMAL;
    endfunction
endpackage

// File: rtl/if_stage_if.sv
// Control, instruction-memory and IF/ID bundle between the fetch stage and its neighbours.
interface if_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic [XLEN-1:0]   redirect_pc;
    logic              mem_busy;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              ifid_valid;
    logic [XLEN-1:0]   ifid_pc;
    logic [XLEN-1:0]   ifid_pc4;
    logic [31:0]       ifid_instr;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        input  stall, flush, redirect_pc, mem_busy, imem_rdata,
        output imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, bubble_cnt
    );
    modport slave (
        output stall, flush, redirect_pc, mem_busy, imem_rdata,
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc4, ifid_instr, bubble_cnt
    );
endinterface

// File: rtl/if_stage_ifid_reg.sv
// Generic pipeline register: async reset, bubble injection (priority) or load, else hold.
module ifid_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] BUB_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         q <= RST_VAL;
        else if (bubble) q <= BUB_VAL;
        else if (load)   q <= d;
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID capture and bubble counter.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          XLEN      = XLEN_D,
    parameter int          ADDR_W    = ADDR_W_D,
    parameter logic [31:0] RESET_PC  = RESET_PC_D,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_D,
    parameter int          CNT_W     = CNT_W_D
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    localparam int            IW  = 1 + 2 * XLEN + 32;
    localparam logic [IW-1:0] BUB = {1'b0, {(2 * XLEN){1'b0}}, NOP_INSTR};

    logic [XLEN-1:0]  pc, pc_next, pc4;
    logic [IW-1:0]    ifid_q;
    logic [CNT_W-1:0] cnt;
    logic             bubble, load;
    if_act_e          act;

    assign act           = if_action(bus.flush, bus.stall, bus.mem_busy);
    assign bubble        = (act == ACT_FLUSH) || (act == ACT_MEM_BUSY);
    assign load          = (act == ACT_NORMAL);
    assign pc4           = pc + XLEN'(4);
    assign bus.imem_addr = pc[ADDR_W+1:2];

    always_comb begin
        pc_next = pc;
        unique case (act)
            ACT_FLUSH:  pc_next = bus.redirect_pc & ~XLEN'(3);
            ACT_NORMAL: pc_next = pc4;
            default:    pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= XLEN'(RESET_PC);
        else     pc <= pc_next;
    end

    // imem_rdata only enters through the load path, so junk on it during bubbles is dropped.
    ifid_reg #(.W(IW), .RST_VAL(BUB), .BUB_VAL(BUB)) u_ifid (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bubble (bubble),
        .d      ({1'b1, pc, pc4, bus.imem_rdata}),
        .q      (ifid_q)
    );

    assign {bus.ifid_valid, bus.ifid_pc, bus.ifid_pc4, bus.ifid_instr} = ifid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= '0;
        else if (bubble && cnt != '1)   cnt <= cnt + CNT_W'(1);
    end

    assign bus.bubble_cnt = cnt;
endmodule
